// File: rtl/apb_copy_engine.sv
// rtl/apb_copy_engine.sv - request-driven APB word copy engine (read source, write destination)
module apb_copy_engine #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              valid,
    output logic              ready,
    input  logic [3:0]        length,
    input  logic [ADDR_W-1:0] source,
    input  logic [ADDR_W-1:0] destination,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_ACCESS,
        WR_SETUP,
        WR_ACCESS,
        DONE
    } state_t;

    state_t            state, state_d;
    logic [3:0]        cnt, cnt_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              err_q, err_d;

    logic              ready_d, psel_d, penable_d, pwrite_d, done_d, err_out_d;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_d;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        src_d   = src_q;
        dst_d   = dst_q;
        buf_d   = buf_q;
        err_d   = err_q;
        case (state)
            IDLE: begin
                if (valid && ready) begin
                    cnt_d   = length;
                    src_d   = source;
                    dst_d   = destination;
                    err_d   = 1'b0;
                    state_d = (length != 4'd0) ? RD_SETUP : DONE;
                end
            end
            RD_SETUP: state_d = RD_ACCESS;
            RD_ACCESS: begin
                if (pready) begin
                    if (pslverr) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        buf_d   = prdata;
                        state_d = WR_SETUP;
                    end
                end
            end
            WR_SETUP: state_d = WR_ACCESS;
            WR_ACCESS: begin
                if (pready) begin
                    if (pslverr) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt - 4'd1;
                        src_d   = src_q + 1'b1;
                        dst_d   = dst_q + 1'b1;
                        state_d = (cnt == 4'd1) ? DONE : RD_SETUP;
                    end
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each state's APB levels
    // appear exactly while the FSM sits in that state.
    always_comb begin
        ready_d   = (state_d == IDLE);
        psel_d    = (state_d == RD_SETUP) || (state_d == RD_ACCESS) ||
                    (state_d == WR_SETUP) || (state_d == WR_ACCESS);
        penable_d = (state_d == RD_ACCESS) || (state_d == WR_ACCESS);
        pwrite_d  = (state_d == WR_SETUP) || (state_d == WR_ACCESS);
        done_d    = (state_d == DONE);
        err_out_d = (state_d == DONE) && err_d;
        paddr_d   = paddr;
        pwdata_d  = pwdata;
        if (state_d == RD_SETUP) begin
            paddr_d = src_d;
        end else if (state_d == WR_SETUP) begin
            paddr_d  = dst_d;
            pwdata_d = buf_d;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            cnt     <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
            ready   <= 1'b0;
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
            ready   <= ready_d;
            psel    <= psel_d;
            penable <= penable_d;
            pwrite  <= pwrite_d;
            paddr   <= paddr_d;
            pwdata  <= pwdata_d;
            done    <= done_d;
            err     <= err_out_d;
        end
    end

endmodule

// File: tb/tb_apb_copy_engine.sv
// tb/tb_apb_copy_engine.sv - directed bench for apb_copy_engine with an APB memory slave model
`timescale 1ns/1ps
module tb_apb_copy_engine;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       valid = 1'b0;
    logic       ready;
    logic [3:0] length = '0;
    logic [7:0] source = '0, destination = '0;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic [7:0] prdata = '0;
    logic       pready = 1'b0, pslverr = 1'b0;
    logic       done, err;

    apb_copy_engine #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk(clk), .nrst(nrst), .valid(valid), .ready(ready), .length(length),
        .source(source), .destination(destination), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [7:0] mem [256];
    logic [7:0] wr_addr [64];
    logic [7:0] wr_data [64];
    logic [7:0] rd_addr [64];
    int nw = 0, nr = 0, psel_cnt = 0;
    int nwait = 0;
    int err_at = -1;
    int wcnt = 0;
    logic [7:0] s_addr, s_wdata;
    logic       s_write;

    // Slave response and protocol stability, evaluated away from the clock edge
    always @(negedge clk) begin
        if (nrst && psel && !penable) begin
            s_addr  = paddr;
            s_write = pwrite;
            s_wdata = pwdata;
            pready  = 1'b0;
            pslverr = 1'b0;
            wcnt    = 0;
        end else if (nrst && psel && penable) begin
            check("stable_paddr", {24'd0, paddr}, {24'd0, s_addr});
            check("stable_pwrite", {31'd0, pwrite}, {31'd0, s_write});
            check("stable_pwdata", {24'd0, pwdata}, {24'd0, s_wdata});
            pready  = (wcnt == nwait);
            pslverr = pready && !pwrite && (nr == err_at);
            if (pready && !pwrite) prdata = mem[paddr];
            wcnt = pready ? 0 : wcnt + 1;
        end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
            wcnt    = 0;
        end
    end

    always @(posedge clk) begin
        if (nrst && psel) psel_cnt++;
        if (nrst && psel && penable && pready) begin
            if (pwrite && !pslverr) begin
                mem[paddr]  = pwdata;
                wr_addr[nw] = paddr;
                wr_data[nw] = pwdata;
                nw++;
            end else if (!pwrite) begin
                rd_addr[nr] = paddr;
                nr++;
            end
        end
    end

    task automatic run_req(input int len, input logic [7:0] src, input logic [7:0] dst,
                           input int waits, input int errat, input int exp_n,
                           input logic exp_err, input int exp_writes);
        logic [7:0] exp_d [16];
        logic [7:0] a;
        int n, bud, exp_reads;
        for (int i = 0; i < 16; i++) begin
            a = src + i[7:0];
            exp_d[i] = mem[a];
        end
        exp_reads = (errat >= 0) ? errat + 1 : len;
        nwait = waits; err_at = errat;
        nw = 0; nr = 0; psel_cnt = 0;
        valid = 1'b1; length = len[3:0]; source = src; destination = dst;
        bud = 0;
        while (!ready && bud < 100) begin
            @(negedge clk);
            bud++;
        end
        check("accept_timeout", {31'd0, ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        n = 1;
        while (!done && n < 300) begin
            check("busy_ready", {31'd0, ready}, 32'd0);
            @(negedge clk);
            n++;
        end
        check("done_cycle", n, exp_n);
        check("done_err", {31'd0, err}, {31'd0, exp_err});
        @(negedge clk);
        check("done_pulse_low", {31'd0, done}, 32'd0);
        check("ready_after_done", {31'd0, ready}, 32'd1);
        check("write_count", nw, exp_writes);
        check("read_count", nr, exp_reads);
        check("psel_cycles", psel_cnt, (nr + nw) * (2 + waits));
        for (int i = 0; i < nw; i++) begin
            check("wr_addr", {24'd0, wr_addr[i]}, {24'd0, dst + i[7:0]});
            check("wr_data", {24'd0, wr_data[i]}, {24'd0, exp_d[i]});
        end
        for (int i = 0; i < nr; i++)
            check("rd_addr", {24'd0, rd_addr[i]}, {24'd0, src + i[7:0]});
    endtask

    initial begin
        int bud;
        for (int i = 0; i < 256; i++) mem[i] = i[7:0] ^ 8'h5A;
        mem[8'h10] = 8'hA5;
        #12;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_psel", {31'd0, psel}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_paddr", {24'd0, paddr}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("ready_after_release", {31'd0, ready}, 32'd1);

        run_req(1, 8'h10, 8'h80, 0, -1, 5, 1'b0, 1);
        check("copied_a5", {24'd0, mem[8'h80]}, 32'h000000A5);
        run_req(3, 8'hFE, 8'h20, 0, -1, 13, 1'b0, 3);
        check("wrap_data", {24'd0, mem[8'h22]}, 32'h0000005A);
        run_req(0, 8'h33, 8'h44, 0, -1, 1, 1'b0, 0);
        run_req(2, 8'h30, 8'h60, 2, -1, 17, 1'b0, 2);
        run_req(4, 8'hA0, 8'hC0, 0, 2, 11, 1'b1, 2);
        run_req(2, 8'hA0, 8'hD0, 0, -1, 9, 1'b0, 2);

        // Asynchronous reset landing in the middle of a write access
        nwait = 2; err_at = -1;
        valid = 1'b1; length = 4'd2; source = 8'h50; destination = 8'h70;
        bud = 0;
        while (!ready && bud < 100) begin @(negedge clk); bud++; end
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        bud = 0;
        while (!(psel && penable && pwrite) && bud < 100) begin @(negedge clk); bud++; end
        check("reach_wr_access", {31'd0, psel && penable && pwrite}, 32'd1);
        #2 nrst = 1'b0;
        #1;
        check("async_psel", {31'd0, psel}, 32'd0);
        check("async_penable", {31'd0, penable}, 32'd0);
        check("async_ready", {31'd0, ready}, 32'd0);
        check("async_done", {31'd0, done}, 32'd0);
        valid = 1'b1; length = 4'd1; source = 8'h11; destination = 8'h91;
        @(negedge clk);
        check("held_rst_ready", {31'd0, ready}, 32'd0);
        nrst = 1'b1;
        @(negedge clk);
        check("ready_first_edge", {31'd0, ready}, 32'd1);
        check("no_psel_before_accept", {31'd0, psel}, 32'd0);
        run_req(1, 8'h11, 8'h91, 0, -1, 5, 1'b0, 1);
        check("post_rst_data", {24'd0, mem[8'h91]}, {24'd0, 8'h11 ^ 8'h5A});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_copy_engine.md
Name: apb_copy_engine

Overview:
- Consumes copy requests from the master request channel: valid/ready handshake carrying length, source and destination.
- Executes each request as a sequence of APB read-then-write word transfers: reads at source+i, writes to destination+i, for i = 0..length-1.
- Sits directly downstream of the request master; drives an APB master port toward the peripheral/memory slave.
- Reports completion and error with a one-cycle done pulse.

Parameters:
- DATA_W, 8, APB data width (prdata/pwdata and internal word buffer).
- ADDR_W, 8, APB address width; must equal request source/destination width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- nrst  in  1  asynchronous active-low reset
- valid  in  1  request valid from master
- ready  out  1  engine can accept a request
- length  in  4  number of words to copy (0..15)
- source  in  ADDR_W  first read address
- destination  in  ADDR_W  first write address
- psel  out  1  APB select
- penable  out  1  APB enable (access phase)
- pwrite  out  1  1 = write, 0 = read
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB slave ready
- pslverr  in  1  APB slave error, sampled with pready
- done  out  1  one-cycle pulse, request finished
- err  out  1  valid with done; 1 = aborted on pslverr

Behaviour:
- Reset: asynchronous on nrst low; takes effect immediately, including mid-transfer.
  - State = IDLE.
  - ready, psel, penable, pwrite, done and err = 0.
  - paddr, pwdata, word buffer and counters = 0.
- ready is registered: next value = (next_state == IDLE).
  - Rises on the first edge after reset release.
  - Falls on the edge that accepts a request.
- Accept: at an edge where valid && ready, capture length into cnt, source into src_q and destination into dst_q.
  - valid while ready = 0 is ignored; master holds the request.
- FSM states: IDLE, RD_SETUP, RD_ACCESS, WR_SETUP, WR_ACCESS, DONE. All APB outputs are registered per state.
- IDLE: on accept with length != 0 -> RD_SETUP; with length == 0 -> DONE (no APB activity).
- RD_SETUP: psel = 1, penable = 0, pwrite = 0, paddr = src_q -> RD_ACCESS.
- RD_ACCESS: psel = 1, penable = 1. Stays here while pready = 0, with all APB outputs stable.
  - pready && !pslverr: capture prdata into buffer -> WR_SETUP.
  - pready && pslverr: err_q = 1 -> DONE.
- WR_SETUP: psel = 1, penable = 0, pwrite = 1, paddr = dst_q, pwdata = buffer -> WR_ACCESS.
- WR_ACCESS: psel = 1, penable = 1. Waits for pready.
  - pready && pslverr: err_q = 1 -> DONE.
  - pready && !pslverr: cnt -= 1, src_q += 1, dst_q += 1.
  - Then, if cnt was 1 -> DONE, else -> RD_SETUP.
- psel = 0 and penable = 0 in IDLE and DONE.
- DONE: done = 1 and err = err_q for exactly one cycle -> IDLE; err_q is cleared on leaving DONE.
- Address arithmetic: modulo 2^ADDR_W, so 0xFF + 1 wraps to 0x00. No carry or flag is produced.
- Latency, zero-wait slave:
  - Accept at T0; first RD_SETUP at T1.
  - 4 cycles per word.
  - done at T0 + 4*length + 1; ready = 1 at the following edge.
  - length = 0: done at T1, ready at T2.
- Exactly one request is in flight at a time; no queuing.

Test Plan:
- length=1, source=0x10, destination=0x80, mem[0x10]=0xA5, zero-wait -> APB read 0x10, then write 0x80 with data 0xA5; done=1, err=0 at T5; ready=1 at T6.
- length=3, source=0xFE, destination=0x20 -> reads 0xFE, 0xFF, 0x00; writes 0x20, 0x21, 0x22 with the matching data; one done pulse at T13.
- length=0 -> no psel activity; done=1, err=0 at T1; ready=1 at T2.
- Slave inserts 2 wait states on every access -> psel, penable, paddr, pwrite and pwdata stable during the waits; data copied correctly; done at T0 + 8*length + 1.
- length=4, pslverr on the read of word 2 -> words 0 and 1 written; no write for word 2 onward; done=1 with err=1; next request completes with err=0.
- nrst low during WR_ACCESS -> psel, penable, ready and done = 0 immediately; after release ready=1 on the first edge; valid held high while busy is accepted only once ready=1.
